fifo_control_unit: RTL and testbench
====================================

# fifo_control_unit

Pointer and status controller for the FIFO register file: converts `push`/`pop` requests into write address, read address and write enable, and reports occupancy flags. The datapath is a `DEPTH`-entry register file, written at `w_addr` on the clock edge when `we` is high, with a combinational read at `r_addr`. Together they form the team's synchronous FIFO. This block owns all FIFO state; the register file holds only data.

## Interface
- `DEPTH`, 4 — number of entries; power of two, ≥ 2.
- `AFULL_TH`, DEPTH-1 — `almost_full` asserts when count ≥ this value; range 1..DEPTH.
- `AEMPTY_TH`, 1 — `almost_empty` asserts when count ≤ this value; range 0..DEPTH-1.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `push`  in  1  — write request; data is presented to the register file in the same cycle.
- `pop`  in  1  — read request; consumes the word currently at `r_addr`.
- `clr_err`  in  1  — clears the sticky error flags.
- `w_addr`  out  $clog2(DEPTH)  — write address to the register file.
- `r_addr`  out  $clog2(DEPTH)  — read address to the register file.
- `we`  out  1  — write enable to the register file; combinational.
- `full`  out  1  — count == DEPTH.
- `empty`  out  1  — count == 0.
- `almost_full`  out  1  — count ≥ AFULL_TH.
- `almost_empty`  out  1  — count ≤ AEMPTY_TH.
- `count`  out  $clog2(DEPTH)+1  — current occupancy, 0..DEPTH.
- `overflow`  out  1  — sticky; a push was rejected.
- `underflow`  out  1  — sticky; a pop was rejected.

## Operation
- **State.** The block keeps registered write and read pointers, each $clog2(DEPTH)+1 bits wide (the extra MSB is a wrap bit). `w_addr` and `r_addr` are the pointer LSBs.
- **Count.** count = wptr − rptr, computed modulo 2^($clog2(DEPTH)+1).
  - `full` when the LSBs are equal and the MSBs differ.
  - `empty` when the pointers are equal.
- **Occupancy classes.** EMPTY (count 0), PARTIAL (0 < count < DEPTH), FULL (count DEPTH). These are derived from the pointers; no separate state register.
- **Acceptance.**
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
  - we = push_ok & ~rst.
- **Pointer update on the clock edge.** If push_ok, wptr += 1. If pop_ok, rptr += 1. Both wrap naturally at 2·DEPTH.
- **Simultaneous push and pop.**
  - PARTIAL: both accepted; count unchanged.
  - FULL: both accepted. The pop reads the old word combinationally and the write replaces that same slot at the edge. Count stays DEPTH.
  - EMPTY: push accepted, pop rejected and `underflow` is set. Count becomes 1.
- **Errors.**
  - `overflow` is set on push & ~push_ok.
  - `underflow` is set on pop & ~pop_ok.
  - Both flags are sticky until `clr_err` or `rst`.
  - If `clr_err` coincides with a new error, the flag stays set (set wins).
- **Reset.**
  - Pointers 0, count 0.
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (for AFULL_TH ≥ 1).
  - `overflow`=0, `underflow`=0, `we`=0.
  - Reset asserted mid-operation discards all contents on that edge. Any push or pop in the reset cycle is ignored and sets no error flag.

## Timing
- **Push latency.** `we` goes high in the same cycle as an accepted push. The data is in the register file after that edge, and the word is visible at the read port in the next cycle if the FIFO was empty.
- **Pop data.** Read data is valid combinationally whenever `empty`=0; no read latency. `pop` only advances `r_addr` at the edge.
- **Status outputs.** `count`, `full`, `empty`, `almost_*` and the error flags are registered or derived purely from registered pointers. They reflect a request one edge after it is accepted, and are glitch-free relative to inputs.
- **Wrap.** After DEPTH pushes and pops, `w_addr` and `r_addr` return to 0 while the wrap bit toggles. Flags stay correct across any number of wraps.

## Test plan
- **Reset state.** Reset, then idle → `empty`=1, `count`=0, `w_addr`=`r_addr`=0, `we`=0, error flags 0.
- **Fill.** DEPTH=4: push 0xA1..0xA4 on 4 consecutive cycles → `count` 1,2,3,4. `almost_full` rises at count 3; `full`=1 after the 4th edge. A 5th push gives `we`=0 and `overflow`=1, with contents unchanged.
- **Drain.** Pop 4 times from full → read data 0xA1..0xA4 in order, `empty`=1. A 5th pop gives `underflow`=1 and `r_addr` stays 0. `clr_err` clears both flags.
- **Simultaneous push and pop.** Push+pop while full → `we`=1 and `count` stays 4. Push+pop while empty → `count`=1 and `underflow`=1. Push+pop at count 2 → `count` stays 2.
- **Wrap-around.** 10 push/pop pairs offset by 1 cycle → data order is preserved, pointers wrap past 3→0 twice, and `count` never exceeds 1.
- **Mid-operation reset.** `rst` with count 3 and a concurrent push → next cycle `count`=0, `empty`=1, no error flags set.

Source files
------------

// File: rtl/fifo_control_unit_if.sv
// Handshake and status bundle between a FIFO user and its pointer/status controller.
// The master issues requests; the slave (controller) drives addresses and flags.
interface fifo_control_unit_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          push;
  logic          pop;
  logic          clr_err;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          we;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, clr_err,
    input  w_addr, r_addr, we, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err,
    output w_addr, r_addr, we, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_control_unit.sv
// Pointer and status controller for a synchronous FIFO built around an external register file.
// Owns the wrap-bit read/write pointers and the sticky error flags; the register file holds data only.
module fifo_control_unit #(
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_control_unit_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    // Modular subtraction of wrap-bit pointers yields occupancy 0..DEPTH directly.
    count   = wptr_q - rptr_q;
    full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    empty   = (wptr_q == rptr_q);
    push_ok = bus.push & (~full | bus.pop);
    pop_ok  = bus.pop & ~empty;

    wptr_d      = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = pop_ok  ? rptr_q + PW'(1) : rptr_q;
    overflow_d  = (bus.push & ~push_ok) | (overflow_q  & ~bus.clr_err);
    underflow_d = (bus.pop  & ~pop_ok)  | (underflow_q & ~bus.clr_err);
  end

  // NOTE: reset takes priority over every request, so a push or pop in the reset cycle is dropped without flagging an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.we           = push_ok & ~rst;
  assign bus.w_addr       = wptr_q[AW-1:0];
  assign bus.r_addr       = rptr_q[AW-1:0];
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= PW'(AFULL_TH));
  assign bus.almost_empty = (count <= PW'(AEMPTY_TH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_control_unit.sv
// Self-checking bench: a queue-based FIFO model plus a behavioural register file,
// driven by directed scenarios and a randomized push/pop/clear/reset mix.
module tb_fifo_control_unit;
  localparam int DEPTH     = 4;
  localparam int AFULL_TH  = DEPTH - 1;
  localparam int AEMPTY_TH = 1;
  localparam int AW        = $clog2(DEPTH);

  logic clk;
  logic rst;
  logic [7:0] wdata;
  logic [7:0] mem [DEPTH];
  logic [7:0] rd;

  fifo_control_unit_if #(.DEPTH(DEPTH)) bus ();

  fifo_control_unit #(
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file the controller addresses.
  always @(posedge clk) if (bus.we) mem[bus.w_addr] <= wdata;
  assign rd = mem[bus.r_addr];

  // Reference model state.
  logic [7:0] q[$];
  bit  m_ov, m_uf;
  int  wcnt, rcnt;
  int  n_checks = 0;
  int  n_fail   = 0;

  // One clock of stimulus: drive at negedge, compare against the model, then advance the model at the edge.
  task automatic step(input bit p, input bit o, input bit c, input bit r, input logic [7:0] d);
    bit pa, oa, exp_we;
    int n;
    logic [16:0] exp_st, got_st;
    @(negedge clk);
    bus.push = p; bus.pop = o; bus.clr_err = c; rst = r; wdata = d;
    #1;
    n      = q.size();
    pa     = p && (n < DEPTH || o);
    oa     = o && (n > 0);
    exp_we = pa && !r;
    n_checks++;
    if (bus.we !== exp_we) begin
      n_fail++;
      $display("FAIL we: got %b expected %b (size %0d push %b pop %b rst %b)", bus.we, exp_we, n, p, o, r);
    end
    exp_st = {3'(n), n == DEPTH, n == 0, n >= AFULL_TH, n <= AEMPTY_TH, m_ov, m_uf,
              AW'(wcnt % DEPTH), AW'(rcnt % DEPTH), 4'b0};
    got_st = {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
              bus.overflow, bus.underflow, bus.w_addr, bus.r_addr, 4'b0};
    n_checks++;
    if (got_st !== exp_st) begin
      n_fail++;
      $display("FAIL status {count,full,empty,af,ae,ov,uf,wa,ra}: got %h expected %h", got_st, exp_st);
    end
    if (n > 0) begin
      n_checks++;
      if (rd !== q[0]) begin
        n_fail++;
        $display("FAIL read_data: got %h expected %h", rd, q[0]);
      end
    end
    @(posedge clk);
    if (r) begin
      q.delete(); m_ov = 0; m_uf = 0; wcnt = 0; rcnt = 0;
    end else begin
      if (oa) begin void'(q.pop_front()); rcnt++; end
      if (pa) begin q.push_back(d); wcnt++; end
      m_ov = (p && !pa) || (m_ov && !c);
      m_uf = (o && !oa) || (m_uf && !c);
    end
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 0, 1, 8'h55);
    step(0, 0, 0, 0, 8'h00);
    #1;
    n_checks++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.we !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.w_addr !== 2'd0 || bus.r_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: empty %b count %0d we %b ov %b uf %b wa %0d ra %0d required 1 0 0 0 0 0 0",
               bus.empty, bus.count, bus.we, bus.overflow, bus.underflow, bus.w_addr, bus.r_addr);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0, 8'hA1 + 8'(i));
      #1;
      n_checks++;
      if (bus.count !== 3'(i + 1) || bus.almost_full !== (i + 1 >= 3)) begin
        n_fail++;
        $display("FAIL fill_count: count %0d af %b required %0d %b", bus.count, bus.almost_full, i + 1, (i + 1 >= 3));
      end
    end
    n_checks++;
    if (bus.full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: got %b required 1", bus.full);
    end
    step(1, 0, 0, 0, 8'hEE);
    #1;
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_set: ov %b count %0d required 1 4", bus.overflow, bus.count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      n_checks++;
      if (rd !== 8'hA1 + 8'(i)) begin
        n_fail++;
        $display("FAIL drain_data: got %h required %h", rd, 8'hA1 + 8'(i));
      end
      step(0, 1, 0, 0, 8'h00);
    end
    step(0, 1, 0, 0, 8'h00);
    #1;
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.r_addr !== 2'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_set: uf %b ra %0d empty %b required 1 0 1", bus.underflow, bus.r_addr, bus.empty);
    end
    step(0, 0, 1, 0, 8'h00);
    #1;
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: ov %b uf %b required 0 0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 8'hB0 + 8'(i));
    step(1, 1, 0, 0, 8'hC0);
    #1;
    n_checks++;
    if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_full: count %0d ov %b required 4 0", bus.count, bus.overflow);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'hC1);
    #1;
    n_checks++;
    if (bus.count !== 3'd1 || bus.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_empty: count %0d uf %b required 1 1", bus.count, bus.underflow);
    end
    step(1, 0, 1, 0, 8'hC2);
    step(1, 1, 0, 0, 8'hC3);
    #1;
    n_checks++;
    if (bus.count !== 3'd2) begin
      n_fail++;
      $display("FAIL pushpop_partial: count %0d required 2", bus.count);
    end
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
  endtask

  task automatic test_wrap();
    int max_cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      step(i < 10, i > 0, 0, 0, 8'hD0 + 8'(i));
      #1;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
    n_checks++;
    if (max_cnt > 1 || bus.empty !== 1'b1 || bus.r_addr !== bus.w_addr) begin
      n_fail++;
      $display("FAIL wrap: max_count %0d empty %b ra %0d wa %0d required <=1 1 equal",
               max_cnt, bus.empty, bus.r_addr, bus.w_addr);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'hE0 + 8'(i));
    step(1, 1, 0, 1, 8'hEF);
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: count %0d empty %b ov %b uf %b required 0 1 0 0",
               bus.count, bus.empty, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 2), 8'($urandom));
    end
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.clr_err = 0; rst = 1; wdata = '0;
    m_ov = 0; m_uf = 0; wcnt = 0; rcnt = 0;
    @(posedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
